mb_add_sched: RTL and testbench
===============================

# mb_add_sched

Multi-byte add scheduler that shares one 8-bit ripple-carry adder slice between two requesters. Each request is an NBYTES-wide addition, executed one byte per cycle, least-significant byte first, with the carry held in a register between bytes. Requesters are arbitrated round-robin, and results are returned on a single valid/ready response channel tagged with the requester id. It sits between operand producers and the shared 8-bit adder datapath.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a, req0_b  in  8*NBYTES  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester the result belongs to.
- rsp_sum  out  8*NBYTES  sum modulo 2^(8*NBYTES).
- rsp_cout  out  1  carry out of the top byte.

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE, grant:
  - Only one requester valid: grant it.
  - Both valid: grant the one not served last.
  - Last-served is initialised to 1 at reset, so requester 0 wins the first tie.
- IDLE, ready: reqX_ready = (state==IDLE) && granted==X, combinational. Ready never asserts for both requesters, nor outside IDLE.
- Accept (valid && ready): latch a, b, cin and id; set byte index to 0 and carry register to cin; go to RUN.
- RUN: each cycle, the slice adds a[idx], b[idx] and the carry register.
  - Sum byte is written to result[idx]; carry register takes the slice carry; idx increments.
  - When idx == NBYTES-1: go to RESP; rsp_cout takes the final carry.
- RESP: rsp_valid=1; rsp_id, rsp_sum and rsp_cout are held stable.
  - On rsp_ready: update last-served to rsp_id and go to IDLE.
  - rsp_ready low stalls indefinitely; no new request is accepted.
- Requester rules: valid must be held, with stable operands, until ready. An unaccepted requester keeps waiting; no request is dropped.
- Width rule: the sum wraps modulo 2^(8*NBYTES); overflow is reported only via rsp_cout.
- NBYTES=1: RUN lasts exactly one cycle.

## Timing
- Reset values: all ready outputs 0; rsp_valid 0; rsp_id 0; rsp_sum 0; rsp_cout 0; state IDLE; last-served 1.
- Request accepted at edge T: RUN occupies cycles T+1..T+NBYTES; rsp_valid is high from T+NBYTES+1.
- Minimum latency is NBYTES+1 cycles.
- After the response handshake at edge R, the FSM is in IDLE at R+1, so the earliest next acceptance is edge R+1.
- Throughput: 1 result per NBYTES+2 cycles.
- Simultaneous valid: resolved by round-robin as above; the loser's ready stays 0.
- Reset asserted mid-RUN or mid-RESP:
  - All state clears immediately; the in-flight operation is discarded and no response is issued.
  - After rst_n rises, requests are taken afresh.
- Valid deasserted while not ready: no effect.

## Structure
- Shared package: FSM state enum (IDLE, RUN, RESP); an id-width constant.
- Sub-module add8_slice: combinational 8-bit ripple-carry adder.
  - Ports: a[7:0], b[7:0], cin → sum[7:0], cout.
  - Instantiated once; the only arithmetic in the block.
- Top level holds the FSM, arbiter, operand/result registers, byte index counter (width clog2(NBYTES), minimum 1) and carry register.

## Test plan
All scenarios use NBYTES=4.
- Single requester: req0 a=0xFFFFFFFF, b=0x00000001, cin=0.
  - rsp_sum=0x00000000, rsp_cout=1, rsp_id=0.
  - rsp_valid rises exactly 5 cycles after acceptance.
- Carry-in only: a=0x12345678, b=0x11111111, cin=1 → rsp_sum=0x23456789+1=0x2345678A, rsp_cout=0.
- Tie arbitration: both valid at reset release → order of service req0, req1, req0 across three back-to-back rounds, with req1_ready never high in the same cycle as req0_ready.
- Backpressure: rsp_ready held 0 for 10 cycles.
  - rsp_valid, rsp_sum and rsp_id are stable throughout.
  - Both ready outputs stay 0.
  - Response completes on the first cycle rsp_ready=1.
- Reset mid-RUN: rst_n pulsed low 2 cycles after acceptance → rsp_valid never asserts for that request; all outputs are 0 during reset.
- Random: 500 randomized requests from both ports with random rsp_ready.
  - {rsp_cout, rsp_sum} == a+b+cin for every response.
  - rsp_id matches the accepted requester.
  - No request is lost or duplicated.

Source files
------------

// File: rtl/mb_add_sched_pkg.sv
// rtl/mb_add_sched_pkg.sv - shared types and constants for the multi-byte add scheduler
package mb_add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ID_W = 1;

endpackage

// File: rtl/add8_slice.sv
// rtl/add8_slice.sv - combinational 8-bit ripple-carry adder slice
module add8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = 8'd0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/mb_add_sched.sv
// rtl/mb_add_sched.sv - round-robin scheduler sharing one 8-bit adder slice between two requesters
module mb_add_sched
    import mb_add_sched_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state, state_nx;
    logic              last_q;
    logic [ID_W-1:0]   id_q;
    logic [W-1:0]      a_q, b_q, sum_q;
    logic              cout_q;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic              any_valid;
    logic              gnt;
    logic              accept;
    logic [7:0]        s_sum;
    logic              s_cout;

    // On a tie the requester not served last wins; otherwise whoever is valid.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        gnt       = 1'b0;
        if (req0_valid && req1_valid)
            gnt = ~last_q;
        else
            gnt = req1_valid;
    end

    assign req0_ready = (state == IDLE) && any_valid && !gnt;
    assign req1_ready = (state == IDLE) && any_valid && gnt;
    assign accept     = req0_ready | req1_ready;

    add8_slice u_slice (
        .a    (a_q[{idx, 3'b000} +: 8]),
        .b    (b_q[{idx, 3'b000} +: 8]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (idx == LAST_IDX) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_q <= 1'b1;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= gnt ? req1_a   : req0_a;
                        b_q   <= gnt ? req1_b   : req0_b;
                        carry <= gnt ? req1_cin : req0_cin;
                        id_q  <= gnt;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_q[{idx, 3'b000} +: 8] <= s_sum;
                    carry <= s_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX)
                        cout_q <= s_cout;
                end
                RESP: begin
                    if (rsp_ready)
                        last_q <= id_q;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_mb_add_sched.sv
// tb/tb_mb_add_sched.sv - self-checking bench for mb_add_sched with behavioural scoreboard
module tb_mb_add_sched;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_cin;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_cin;
    logic [W-1:0]  req1_a, req1_b;
    logic          rsp_valid, rsp_ready;
    logic [0:0]    rsp_id;
    logic [W-1:0]  rsp_sum;
    logic          rsp_cout;

    always #5 clk = ~clk;

    mb_add_sched #(.NBYTES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: at most one operation in flight, response due N+1 cycles after acceptance.
    bit           busy = 0;
    bit           last_m = 1;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic         exp_id;
    logic [W:0]   exp_full;
    bit           first_rv = 0;
    int           lat = -1;
    bit           acc0_f, acc1_f, hs_f;
    logic [W-1:0] hs_sum;
    logic         hs_cout, hs_id;
    int           n_acc = 0, n_rsp = 0, n_disc = 0, rv_cnt = 0;
    int           order[$];
    bit           prev_stall = 0;
    logic [W-1:0] prev_sum;
    logic         prev_id, prev_cout;
    bit           er0, er1, erv;

    always @(negedge clk) begin
        cyc++;
        hs_f = 0; acc0_f = 0; acc1_f = 0;
        if (!rst_n) begin
            chk("reset_outputs", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum}), 64'd0);
            if (busy) n_disc++;
            busy = 0; last_m = 1; prev_stall = 0;
        end else begin
            er0 = !busy && req0_valid && (!req1_valid || last_m);
            er1 = !busy && req1_valid && (!req0_valid || !last_m);
            chk("ready", 64'({req0_ready, req1_ready}), 64'({er0, er1}));
            erv = busy && (cyc - acc_cyc >= N + 1);
            chk("rsp_valid", 64'(rsp_valid), 64'(erv));
            if (rsp_valid) begin
                rv_cnt++;
                if (first_rv) begin lat = cyc - acc_cyc; first_rv = 0; end
                chk("rsp_id", 64'(rsp_id), 64'(exp_id));
                chk("rsp_cout_sum", 64'({rsp_cout, rsp_sum}), 64'(exp_full));
                if (prev_stall)
                    chk("stall_stable", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({prev_id, prev_cout, prev_sum}));
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_sum = rsp_sum; prev_id = rsp_id; prev_cout = rsp_cout;
            if (rsp_valid && rsp_ready && busy) begin
                hs_f = 1; hs_sum = rsp_sum; hs_cout = rsp_cout; hs_id = rsp_id;
                busy = 0; last_m = exp_id; n_rsp++;
                order.push_back(int'(rsp_id));
            end
            if (req0_valid && req0_ready) begin
                acc0_f = 1; busy = 1; acc_cyc = cyc; first_rv = 1; n_acc++;
                exp_id = 1'b0;
                exp_full = 33'(req0_a) + 33'(req0_b) + 33'(req0_cin);
            end else if (req1_valid && req1_ready) begin
                acc1_f = 1; busy = 1; acc_cyc = cyc; first_rv = 1; n_acc++;
                exp_id = 1'b1;
                exp_full = 33'(req1_a) + 33'(req1_b) + 33'(req1_cin);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int port);
        for (int i = 0; i < 100; i++) begin
            step();
            if ((port == 0) ? acc0_f : acc1_f) return;
        end
        chk("timeout_accept", 64'd0, 64'd1);
    endtask

    task automatic wait_hs();
        for (int i = 0; i < 100; i++) begin
            step();
            if (hs_f) return;
        end
        chk("timeout_response", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) return;
            step();
        end
        chk("timeout_idle", 64'd0, 64'd1);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        v = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 ns");
        $fatal(1);
    end

    initial begin
        int rv0, nr0, start_acc, guard;
        rst_n = 1'b0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
        rsp_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Wraparound: all-ones plus one
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 0;
        wait_acc(0);
        req0_valid = 0;
        wait_hs();
        chk("wrap_sum", 64'(hs_sum), 64'h0);
        chk("wrap_cout", 64'(hs_cout), 64'd1);
        chk("wrap_id", 64'(hs_id), 64'd0);
        chk("latency", 64'(lat), 64'd5);

        // Carry-in propagation
        req0_valid = 1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1;
        wait_acc(0);
        req0_valid = 0;
        wait_hs();
        chk("cin_sum", 64'(hs_sum), 64'h2345_678A);
        chk("cin_cout", 64'(hs_cout), 64'd0);

        // Tie arbitration straight out of reset
        rst_n = 0;
        step(); step();
        order.delete();
        rst_n = 1;
        req0_valid = 1; req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom);
        req1_valid = 1; req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom);
        guard = 0;
        while (order.size() < 3 && guard < 200) begin
            step();
            guard++;
            if (acc0_f) begin req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom); end
            if (acc1_f) begin req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom); end
        end
        req0_valid = 0; req1_valid = 0;
        chk("tie_rounds", 64'(order.size()), 64'd3);
        if (order.size() >= 3) begin
            chk("tie_order0", 64'(order[0]), 64'd0);
            chk("tie_order1", 64'(order[1]), 64'd1);
            chk("tie_order2", 64'(order[2]), 64'd0);
        end
        wait_idle();

        // Backpressure with a competing requester waiting
        rsp_ready = 0;
        req0_valid = 1; req0_a = 32'hDEAD_BEEF; req0_b = 32'h2152_4111; req0_cin = 0;
        wait_acc(0);
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'h0000_00FF; req1_b = 32'h0000_0001; req1_cin = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_held", 64'({rsp_valid, req0_ready, req1_ready}), 64'b100);
        end
        rsp_ready = 1;
        step();
        chk("bp_release", 64'(hs_f), 64'd1);
        chk("bp_sum", 64'({hs_cout, hs_sum}), 64'({1'b1, 32'h0000_0000}));
        wait_acc(1);
        req1_valid = 0;
        wait_hs();
        chk("bp_next_sum", 64'(hs_sum), 64'h0000_0100);

        // Reset two cycles into RUN discards the operation
        req0_valid = 1; req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1;
        wait_acc(0);
        req0_valid = 0;
        step(); step();
        rst_n = 0;
        rv0 = rv_cnt; nr0 = n_rsp;
        step(); step();
        rst_n = 1;
        repeat (10) step();
        chk("reset_no_rsp", 64'(rv_cnt - rv0), 64'd0);
        chk("reset_no_hs", 64'(n_rsp - nr0), 64'd0);

        // Randomized traffic from both ports with random backpressure
        start_acc = n_acc;
        guard = 0;
        while (n_acc - start_acc < 500 && guard < 30000) begin
            if (!req0_valid || acc0_f) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom);
            end
            if (!req1_valid || acc1_f) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            guard++;
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        step();
        wait_idle();
        chk("random_count", 64'(n_acc - start_acc >= 500), 64'd1);
        chk("no_lost_or_dup", 64'(n_acc), 64'(n_rsp + n_disc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
